gray_ptr_rx: RTL and testbench

Receiving end of a Gray-coded pointer crossing. The block takes a Gray count produced by a `gray_cnt` instance, typically in a foreign clock domain, and passes it through an N-stage synchronizer. It then decodes the value to binary and reports each advance with its step size. It also flags any sample that changed more than one bit, which is illegal for Gray code. It is the FIFO-side consumer of the remote write/read pointer.

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_sync.sv | 37 +++
 rtl/gray_ptr_rx.sv | 72 +++++++
 tb/tb_gray_ptr_rx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the pointer crossing, the remote counter and the bench.
// Helpers work on a fixed-width word; narrower values are zero-extended by the caller.
package gray_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef logic [MaxWidth-1:0] gray_word_t;

  // A leading-zero extension does not change the decode of the low bits.
  function automatic gray_word_t g2b(input gray_word_t g);
    gray_word_t b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t b2g(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input gray_word_t w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      n = n + {31'b0, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Plain multi-stage flop chain for a Gray-coded bus crossing into clk.
// No logic between stages so metastability stays confined to the first stage.
module gray_sync
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  always_comb begin
    s_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      s_q <= s_d;
    end
  end

  assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray pointer crossing: synchronize, decode to binary, report
// each advance with its step size and flag any multi-bit change as a sticky error.
module gray_ptr_rx
  import gray_pkg::*;
#(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] gray_in,
  input  logic            clr_err,
  output logic [SIZE-1:0] bin_out,
  output logic            upd,
  output logic [SIZE-1:0] step,
  output logic            err
);

  logic [SIZE-1:0] s_last;
  logic [SIZE-1:0] g_prev_q, g_prev_d;
  logic [SIZE-1:0] bin_q, bin_d;
  logic [SIZE-1:0] bin_prev;
  logic [SIZE-1:0] step_q, step_d;
  logic [SIZE-1:0] diff;
  logic            upd_q, upd_d;
  logic            err_q, err_d;
  logic            multi_bit;

  gray_sync #(
    .WIDTH  (SIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gray_in),
    .q_o   (s_last)
  );

  always_comb begin
    g_prev_d  = s_last;
    diff      = s_last ^ g_prev_q;
    bin_d     = SIZE'(g2b(gray_word_t'(s_last)));
    bin_prev  = SIZE'(g2b(gray_word_t'(g_prev_q)));
    step_d    = bin_d - bin_prev;
    upd_d     = |diff;
    multi_bit = popcount(gray_word_t'(diff)) > 1;
    // A fresh violation outranks a clear requested in the same cycle.
    err_d     = multi_bit | (err_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_prev_q <= '0;
      bin_q    <= '0;
      step_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      g_prev_q <= g_prev_d;
      bin_q    <= bin_d;
      step_q   <= step_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign step    = step_q;
  assign upd     = upd_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Scoreboard bench for gray_ptr_rx (SIZE=4, SYNC_STAGES=2): each driven cycle queues
// the hand-computed output expected after its edge; a negedge monitor checks them.
module tb_gray_ptr_rx;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       upd;
  logic [3:0] step;
  logic       err;

  typedef struct {
    int unsigned due;
    logic [3:0]  bin;
    logic        upd;
    logic [3:0]  step;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  gray_ptr_rx #(
    .SIZE        (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .clr_err (clr_err),
    .bin_out (bin_out),
    .upd     (upd),
    .step    (step),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output registers settle on posedge, compare on the following negedge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.due != cyc ||
          {bin_out, upd, step, err} !== {e.bin, e.upd, e.step, e.err}) begin
        n_fail++;
        $display("FAIL cycle %0d (due %0d): got bin=%0d upd=%0b step=%0d err=%0b, want bin=%0d upd=%0b step=%0d err=%0b",
                 cyc, e.due, bin_out, upd, step, err, e.bin, e.upd, e.step, e.err);
      end
    end
  end

  task automatic row(input logic [3:0] g, input logic rn, input logic c,
                     input logic [3:0] eb, input logic eu, input logic [3:0] es,
                     input logic ee);
    gray_in = g;
    rst_n   = rn;
    clr_err = c;
    sb.push_back('{due: cyc + 1, bin: eb, upd: eu, step: es, err: ee});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a nonzero input.
    row(4'b0110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    // Counting 0..4, three-edge latency.
    row(4'b0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0001, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0011, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0010, 1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b0);
    row(4'b0110, 1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 1'b0);
    row(4'b0110, 1'b1, 1'b0, 4'd3, 1'b1, 4'd1, 1'b0);
    row(4'b0110, 1'b1, 1'b0, 4'd4, 1'b1, 4'd1, 1'b0);
    // Reset, then 1000 (binary 15) followed by 0000 wraps with step 1.
    row(4'b1000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b1000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b1000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0000, 1'b1, 1'b0, 4'd15, 1'b1, 4'd15, 1'b0);
    row(4'b0000, 1'b1, 1'b0, 4'd15, 1'b0, 4'd0, 1'b0);
    row(4'b0000, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
    // Illegal 0000 -> 0011 jump, sticky err, then clear.
    row(4'b0011, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0011, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0011, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1);
    row(4'b0011, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b1);
    row(4'b0011, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    row(4'b0011, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0);
    // 0011 -> 0101 jump reaches the comparator in the same cycle as clr_err.
    row(4'b0101, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0);
    row(4'b0101, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0);
    row(4'b0101, 1'b1, 1'b1, 4'd6, 1'b1, 4'd4, 1'b1);
    row(4'b0101, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 1'b1);
    // Legal 0101 -> 0111 step down, then idle hold.
    row(4'b0111, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 1'b1);
    row(4'b0111, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 1'b1);
    row(4'b0111, 1'b1, 1'b0, 4'd5, 1'b1, 4'd15, 1'b1);
    row(4'b0111, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b1);
    row(4'b0111, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b1);
    // Mid-operation reset, release with 0101 compared against reset value 0.
    row(4'b0101, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0101, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0101, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    row(4'b0101, 1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1);
    row(4'b0101, 1'b1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
